iic_dsdemod: RTL and testbench

- Delta-sigma demodulator: the receive end of the team's single-bit delta-sigma bitstream.
- Takes a 1-bit oversampled stream and produces UINT samples at 1/OSR of the bitstream rate.
- Filter is a 3rd-order CIC (sinc3) decimator. Each output word is pushed into a downstream FIFO with a one-cycle write strobe.
- Midscale (equal ones/zeros density) maps to 0x8000 for BW=16, matching the modulator's UINT convention.

---
 rtl/iic_dsdemod.sv | 97 +++++++++
 tb/tb_iic_dsdemod.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iic_dsdemod.sv
// Single-bit delta-sigma demodulator: sinc3 CIC decimator (OSR 32..256) producing
// UINT samples with a one-cycle FIFO write strobe.
module iic_dsdemod #(
  parameter int BW = 16
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          en_i,
  input  logic          ds_i,
  input  logic [1:0]    osr_i,
  output logic [BW-1:0] data_o,
  output logic          data_wr_o
);

  localparam int W = 25;

  logic         ds_q;
  logic [W-1:0] i1, i2, i3;
  logic [W-1:0] d1, d2, d3;
  logic [W-1:0] c1, c2, c3;
  logic [7:0]   dec_ctr;
  logic [1:0]   osr_q;
  logic [1:0]   wu_ctr;
  logic         tick;

  // Scale c3 (full scale 2^(3k)) to BW bits; exact full scale saturates to all ones.
  function automatic logic [BW-1:0] normalise(input logic [W-1:0] c, input logic [1:0] code);
    logic [W+BW-1:0] wide;
    int              sh;
    sh   = 3 * (5 + int'(code));
    wide = {c, {BW{1'b0}}} >> sh;
    if (c >= (W'(1) << sh)) normalise = '1;
    else                    normalise = wide[BW-1:0];
  endfunction

  // Input register: free-running, carries no control state
  always_ff @(posedge clk_i) begin
    ds_q <= ds_i;
  end

  // Comb stage, evaluated combinationally and committed on a tick
  always_comb begin
    tick = (dec_ctr == 8'd0);
    c1   = i3 - d1;
    c2   = c1 - d2;
    c3   = c2 - d3;
  end

  // Integrators, decimation, combs and output register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      i1        <= '0;
      i2        <= '0;
      i3        <= '0;
      d1        <= '0;
      d2        <= '0;
      d3        <= '0;
      dec_ctr   <= '0;
      osr_q     <= '0;
      wu_ctr    <= '0;
      data_o    <= '0;
      data_wr_o <= 1'b0;
    end else if (!en_i) begin
      i1        <= '0;
      i2        <= '0;
      i3        <= '0;
      d1        <= '0;
      d2        <= '0;
      d3        <= '0;
      dec_ctr   <= '0;
      osr_q     <= '0;
      wu_ctr    <= '0;
      data_o    <= '0;
      data_wr_o <= 1'b0;
    end else begin
      i1        <= i1 + {{(W-1){1'b0}}, ds_q};
      i2        <= i2 + i1;
      i3        <= i3 + i2;
      data_wr_o <= 1'b0;
      if (tick) begin
        dec_ctr <= 8'((9'd32 << osr_i) - 9'd1);
        osr_q   <= osr_i;
        d1      <= i3;
        d2      <= c1;
        d3      <= c2;
        data_o  <= normalise(c3, osr_q);
        // A new ratio invalidates the comb history, so warm-up starts over
        if (osr_i != osr_q)       wu_ctr    <= 2'd0;
        else if (wu_ctr == 2'd3)  data_wr_o <= 1'b1;
        else                      wu_ctr    <= wu_ctr + 2'd1;
      end else begin
        dec_ctr <= dec_ctr - 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_iic_dsdemod.sv
// Bench for iic_dsdemod: sinc3 convolution model over the recorded bitstream,
// checked every cycle, plus directed literal expectations.
module tb_iic_dsdemod;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        ds;
  logic [1:0]  osr;
  logic [15:0] data;
  logic        wr;

  iic_dsdemod #(.BW(16)) dut (
    .clk_i    (clk),
    .rst_n_i  (rst_n),
    .en_i     (en),
    .ds_i     (ds),
    .osr_i    (osr),
    .data_o   (data),
    .data_wr_o(wr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Sinc3 impulse response per ratio: box(R) convolved three times
  int h [4][0:765];
  initial begin
    for (int code = 0; code < 4; code++) begin
      int r;
      r = 32 << code;
      for (int j = 0; j <= 3 * r - 3; j++) begin
        int acc2;
        acc2 = 0;
        for (int a = 0; a < r; a++) begin
          int m;
          m = j - a;
          if (m >= 0 && m <= r - 1)          acc2 += m + 1;
          else if (m >= r && m <= 2 * r - 2) acc2 += 2 * r - 1 - m;
        end
        h[code][j] = acc2;
      end
    end
  end

  bit ds_hist [0:32767];
  int cyc        = 0;
  int run_start  = 0;
  int next_tick  = 0;
  int cur_code   = 0;
  int origin     = 0;
  bit need_start = 1'b1;
  bit exp_zero   = 1'b1;
  bit exp_wr     = 1'b0;
  int exp_data   = 0;

  // Output for the window closing at edge t: kernel applied to samples since the run began
  function automatic int model_out(input int t, input int code);
    longint c;
    int     r, k3;
    r = 32 << code;
    c = 0;
    for (int j = 0; j <= 3 * r - 3; j++) begin
      int s;
      s = t - 3 - j;
      if (s >= run_start && ds_hist[s - 1]) c += h[code][j];
    end
    k3 = 3 * (5 + code);
    if (c >= (64'sd1 <<< k3)) return 'hFFFF;
    return int'((c <<< 16) >>> k3);
  endfunction

  always @(posedge clk) begin
    ds_hist[cyc] = ds;
    exp_wr = 1'b0;
    if (!rst_n || !en) begin
      need_start = 1'b1;
      exp_zero   = 1'b1;
    end else begin
      exp_zero = 1'b0;
      if (need_start) begin
        need_start = 1'b0;
        run_start  = cyc;
        next_tick  = cyc;
        cur_code   = 0;
        origin     = cyc;
      end
      if (cyc == next_tick) begin
        int r;
        r = 32 << osr;
        if (int'(osr) != cur_code) begin
          cur_code = int'(osr);
          origin   = cyc + r;
        end else if (cyc >= origin + 3 * r) begin
          exp_wr   = 1'b1;
          exp_data = model_out(cyc, cur_code);
        end
        next_tick = cyc + r;
      end
    end
    cyc++;
  end

  int first_rel  = -1;
  int first_data = -1;
  int last_data  = -1;
  int prev_st    = -1;
  int gap_q[$];

  always begin
    @(negedge clk);
    #1;
    if (!rst_n || exp_zero) begin
      check("idle_data", int'(data), 0);
      check("idle_wr", int'(wr), 0);
    end else begin
      check("strobe", int'(wr), int'(exp_wr));
      if (exp_wr) check("data", int'(data), exp_data);
    end
    if (wr) begin
      int obs;
      obs = cyc - 1;
      if (first_rel < 0) begin
        first_rel  = obs - run_start;
        first_data = int'(data);
      end
      last_data = int'(data);
      if (prev_st >= 0) gap_q.push_back(obs - prev_st);
      prev_st = obs;
    end
  end

  int mode = 0;
  int dens = 50;
  int acc  = 0;

  task automatic phase_start();
    first_rel  = -1;
    first_data = -1;
    last_data  = -1;
    prev_st    = -1;
    gap_q.delete();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      case (mode)
        0: ds = 1'b1;
        1: ds = 1'b0;
        2: ds = ~ds;
        3: begin
          acc += 'h4000;
          ds = acc[16];
          acc &= 'hFFFF;
        end
        default: ds = ($urandom_range(99) < dens);
      endcase
    end
  endtask

  task automatic drop_en(input int n);
    @(negedge clk);
    en = 1'b0;
    @(posedge clk);
    #1;
    check("en_off_data", int'(data), 0);
    check("en_off_wr", int'(wr), 0);
    run(n - 1);
    en = 1'b1;
  endtask

  initial begin
    int en_off;
    int rst_hold;
    rst_n = 1'b0;
    en    = 1'b0;
    ds    = 1'b1;
    osr   = 2'd0;
    run(3);
    check("rst_data", int'(data), 0);
    check("rst_wr", int'(wr), 0);

    // Constant ones at OSR 32: three silent ticks, then saturated full scale
    mode  = 0;
    rst_n = 1'b1;
    en    = 1'b1;
    phase_start();
    run(200);
    check("ones_first_edge", first_rel, 96);
    check("ones_first_data", first_data, 'hFFFF);
    check("ones_gap", (gap_q.size() > 0) ? gap_q[0] : -1, 32);

    // One-cycle async reset, then constant zeros at OSR 64
    rst_n = 1'b0;
    #1;
    check("async_rst_data", int'(data), 0);
    check("async_rst_wr", int'(wr), 0);
    osr  = 2'd1;
    mode = 1;
    @(negedge clk);
    rst_n = 1'b1;
    phase_start();
    run(64 * 6 + 10);
    check("zeros_data", last_data, 0);
    check("zeros_gap", (gap_q.size() > 0) ? gap_q[0] : -1, 64);

    // Alternating bits give exact midscale at every ratio
    mode = 2;
    for (int code = 0; code < 4; code++) begin
      osr = 2'(code);
      drop_en(5);
      phase_start();
      run(6 * (32 << code));
      check($sformatf("mid_osr%0d", code), last_data, 'h8000);
    end

    // First-order modulator of 0x4000 at OSR 128
    mode = 3;
    acc  = 0;
    osr  = 2'd2;
    drop_en(5);
    phase_start();
    run(6 * 128);
    check("mod4000_close", ((last_data >= 'h3FFE) && (last_data <= 'h4002)) ? 1 : 0, 1);

    // Ratio change 0->2 mid-window
    mode = 4;
    dens = 50;
    osr  = 2'd0;
    drop_en(5);
    phase_start();
    run(141);
    osr = 2'd2;
    run(810);
    check("chg_strobes", gap_q.size(), 4);
    check("chg_gap_restart", (gap_q.size() > 2) ? gap_q[1] : -1, 544);
    check("chg_gap_after", (gap_q.size() > 2) ? gap_q[2] : -1, 128);

    // Reset mid-window and enable drop mid-window, each followed by full warm-up
    dens = 70;
    osr  = 2'd0;
    run(50);
    rst_n = 1'b0;
    #1;
    check("mid_rst_data", int'(data), 0);
    check("mid_rst_wr", int'(wr), 0);
    @(negedge clk);
    rst_n = 1'b1;
    phase_start();
    run(150);
    check("rst_restart_edge", first_rel, 96);
    run(17);
    drop_en(5);
    phase_start();
    run(150);
    check("en_restart_edge", first_rel, 96);

    // Randomized run: density, ratio, enable and reset all vary
    en_off   = 0;
    rst_hold = 0;
    for (int i = 0; i < 12000; i++) begin
      int r;
      run(1);
      r = $urandom_range(1499);
      if (i % 700 == 0) dens = $urandom_range(100);
      if (rst_hold > 0) begin
        rst_hold--;
        if (rst_hold == 0) rst_n = 1'b1;
      end else if (en_off > 0) begin
        en_off--;
        if (en_off == 0) en = 1'b1;
      end else if (r == 0) begin
        osr = 2'($urandom_range(3));
      end else if (r == 1) begin
        en     = 1'b0;
        en_off = $urandom_range(6, 1);
      end else if (r == 2) begin
        rst_n    = 1'b0;
        rst_hold = 1;
      end
    end
    rst_n = 1'b1;
    en    = 1'b1;
    run(4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
